well_state_detector: RTL and testbench
======================================

WELL_STATE_DETECTOR -- requirements
Module: well_state_detector

Interface
REQ-001 Parameter WIDTH, default 16, width of signed data and thresholds (matches exp_filter_ve data_o).
REQ-002 Parameter CNT_WIDTH, default 32, width of dwell and switch counters.
REQ-003 Parameter DEB_WIDTH, default 16, width of debounce setting and pending counter.
REQ-004 clk_i  in  1  single clock; one sample per cycle.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 data_i  in  WIDTH  signed filtered position, from exp_filter_ve data_o.
REQ-007 thr_low_i  in  WIDTH  signed lower hysteresis threshold.
REQ-008 thr_high_i  in  WIDTH  signed upper hysteresis threshold.
REQ-009 debounce_i  in  DEB_WIDTH  unsigned consecutive-sample count to confirm a well; 0 treated as 1.
REQ-010 clear_i  in  1  clears statistics (n_switch_o, dwell_o); does not affect well state.
REQ-011 state_o  out  1  current well: 0 = low well, 1 = high well; meaningful only when valid_o=1.
REQ-012 valid_o  out  1  high once initial well acquired.
REQ-013 switch_o  out  1  one-cycle pulse on confirmed well transition.
REQ-014 dwell_o  out  CNT_WIDTH  unsigned cycles between last two confirmed transitions.
REQ-015 dwell_valid_o  out  1  one-cycle pulse when dwell_o updates.
REQ-016 n_switch_o  out  CNT_WIDTH  unsigned confirmed transition count, saturating.

Function
REQ-017 Compare stage registers hi_flag = (data_i > thr_high_i) and lo_flag = (data_i < thr_low_i), signed strict compares, every cycle.
REQ-018 If hi_flag and lo_flag both set (thr_low_i > thr_high_i), sample treated as in-band (neither flag counts).
REQ-019 FSM states: ACQ (no well), LOW, HIGH, PEND_HIGH (in LOW, candidate high), PEND_LOW (in HIGH, candidate low); ACQ holds separate pending counts for each direction via one counter plus direction bit.
REQ-020 Pending counter increments each cycle the candidate flag is set; any cycle without it clears counter and returns to originating state (ACQ, LOW or HIGH).
REQ-021 Confirmation when counter+1 >= max(debounce_i,1) on a cycle with candidate flag set; debounce_i compared live each cycle.
REQ-022 Timing: if qualifying samples are captured on edges k..k+D-1 (D = effective debounce), state_o, switch_o update on edge k+D.
REQ-023 ACQ -> LOW or HIGH on confirmation: valid_o set, no switch_o, no count, dwell counter loaded to 1, first_dwell flag set.
REQ-024 LOW <-> HIGH on confirmation: state_o toggles, switch_o pulses, n_switch_o increments (saturates at all-ones), dwell counter loaded to 1.
REQ-025 Dwell counter increments every cycle in LOW, HIGH, PEND_*, saturates at all-ones; pending cycles count toward current well.
REQ-026 On transition: if first_dwell clear, dwell_o <= dwell counter value and dwell_valid_o pulses; if set, dwell_o unchanged, first_dwell cleared (truncated residence not reported).
REQ-027 Two transitions N cycles apart yield dwell_o = N.
REQ-028 clear_i: n_switch_o <= 0, dwell_o <= 0; same-cycle transition: n_switch_o <= 1, dwell_o <= 0, dwell_valid_o = 0; state and dwell counter unaffected.
REQ-029 In-band samples (neither flag) never change state.

Reset
REQ-030 rst_i at any edge, including mid-pending: state ACQ, flags 0, pending counter 0, dwell counter 0, first_dwell 1.
REQ-031 Outputs after reset: state_o 0, valid_o 0, switch_o 0, dwell_o 0, dwell_valid_o 0, n_switch_o 0.

Verification
REQ-032 thr -1000/+1000, debounce 4, data 2000 from edge 10 -> valid_o=1, state_o=1 at edge 14, no switch_o.
REQ-033 Acquired HIGH, data -2000 for 4 samples at edge 50 -> switch_o pulse at edge 54, n_switch_o=1, dwell_valid_o=0; return to HIGH after 20 cycles -> dwell_o=20, dwell_valid_o pulse, n_switch_o=2.
REQ-034 In LOW, debounce 4, data 2000 for 3 samples then 0 then 2000 for 3 -> no transition, state_o=0.
REQ-035 thr_low 500, thr_high -500, data 0 then +/-2000 -> in-band at 0; valid transitions at +/-2000; debounce 0 behaves as 1 (1-edge confirm).
REQ-036 clear_i same cycle as transition -> n_switch_o=1, dwell_o=0; rst_i mid-pending -> all outputs reset values next cycle, ACQ restarts.

Source files
------------

// File: rtl/well_state_detector.sv
// Well state detector: classifies a filtered position into a low or high
// well using hysteresis thresholds plus a debounce count, and reports
// transitions, residence time (dwell) and a saturating transition count.
module well_state_detector #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 32,
   parameter int DEB_WIDTH = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic signed [WIDTH-1:0]     data_i,
   input  logic signed [WIDTH-1:0]     thr_low_i,
   input  logic signed [WIDTH-1:0]     thr_high_i,
   input  logic        [DEB_WIDTH-1:0] debounce_i,
   input  logic                        clear_i,
   output logic                        state_o,
   output logic                        valid_o,
   output logic                        switch_o,
   output logic        [CNT_WIDTH-1:0] dwell_o,
   output logic                        dwell_valid_o,
   output logic        [CNT_WIDTH-1:0] n_switch_o
);

   typedef enum logic [2:0] {
      ACQ,
      LOW,
      HIGH,
      PEND_HIGH,
      PEND_LOW
   } state_t;

   state_t                 r_state;
   logic                   r_hi_flag;
   logic                   r_lo_flag;
   logic [DEB_WIDTH-1:0]   r_pend;
   logic                   r_dir;
   logic [CNT_WIDTH-1:0]   r_dwell_cnt;
   logic                   r_first_dwell;
   logic                   r_state_o;
   logic                   r_valid;
   logic                   r_switch;
   logic [CNT_WIDTH-1:0]   r_dwell;
   logic                   r_dwell_valid;
   logic [CNT_WIDTH-1:0]   r_n_switch;

   logic                   w_hi;
   logic                   w_lo;
   logic [DEB_WIDTH:0]     w_deb_eff;
   logic [DEB_WIDTH:0]     w_pend_inc;
   logic [DEB_WIDTH:0]     w_acq_cnt;
   logic                   w_first_ok;
   logic                   w_pend_ok;
   logic                   w_acq_ok;
   logic                   w_acquire;
   logic                   w_go_high;
   logic                   w_go_low;
   logic                   w_switch;
   logic [CNT_WIDTH-1:0]   w_dwell_inc;
   logic [CNT_WIDTH-1:0]   w_nsw_inc;

   // A sample above the upper and below the lower threshold at once
   // (inverted thresholds) counts as in-band.
   assign w_hi = r_hi_flag & ~r_lo_flag;
   assign w_lo = r_lo_flag & ~r_hi_flag;

   // Debounce setting of zero confirms on the first qualifying sample.
   assign w_deb_eff  = (debounce_i == '0) ? (DEB_WIDTH+1)'(1) : {1'b0, debounce_i};
   assign w_pend_inc = {1'b0, r_pend} + (DEB_WIDTH+1)'(1);

   // In ACQ one counter serves both directions: a direction change restarts at 1.
   assign w_acq_cnt  = (w_hi == r_dir) ? w_pend_inc : (DEB_WIDTH+1)'(1);

   assign w_first_ok = ((DEB_WIDTH+1)'(1) >= w_deb_eff);
   assign w_pend_ok  = (w_pend_inc >= w_deb_eff);
   assign w_acq_ok   = (w_acq_cnt >= w_deb_eff);

   assign w_acquire  = (r_state == ACQ) && (w_hi || w_lo) && w_acq_ok;
   assign w_go_high  = w_hi && (((r_state == LOW) && w_first_ok) ||
                                ((r_state == PEND_HIGH) && w_pend_ok));
   assign w_go_low   = w_lo && (((r_state == HIGH) && w_first_ok) ||
                                ((r_state == PEND_LOW) && w_pend_ok));
   assign w_switch   = w_go_high || w_go_low;

   assign w_dwell_inc = (&r_dwell_cnt) ? r_dwell_cnt : r_dwell_cnt + CNT_WIDTH'(1);
   assign w_nsw_inc   = (&r_n_switch)  ? r_n_switch  : r_n_switch + CNT_WIDTH'(1);

   // Compare stage: register threshold crossings of each sample.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_hi_flag <= 1'b0;
         r_lo_flag <= 1'b0;
      end else begin
         r_hi_flag <= (data_i > thr_high_i);
         r_lo_flag <= (data_i < thr_low_i);
      end
   end

   // Well FSM with debounce, dwell measurement and transition statistics.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= ACQ;
         r_pend        <= '0;
         r_dir         <= 1'b0;
         r_dwell_cnt   <= '0;
         r_first_dwell <= 1'b1;
         r_state_o     <= 1'b0;
         r_valid       <= 1'b0;
         r_switch      <= 1'b0;
         r_dwell       <= '0;
         r_dwell_valid <= 1'b0;
         r_n_switch    <= '0;
      end else begin
         r_switch      <= 1'b0;
         r_dwell_valid <= 1'b0;
         if (r_state != ACQ) r_dwell_cnt <= w_dwell_inc;

         case (r_state)
            ACQ: begin
               if (w_acquire) begin
                  r_state       <= w_hi ? HIGH : LOW;
                  r_state_o     <= w_hi;
                  r_valid       <= 1'b1;
                  r_pend        <= '0;
                  r_dwell_cnt   <= CNT_WIDTH'(1);
                  r_first_dwell <= 1'b1;
               end else if (w_hi || w_lo) begin
                  r_pend <= w_acq_cnt[DEB_WIDTH-1:0];
                  r_dir  <= w_hi;
               end else begin
                  r_pend <= '0;
               end
            end
            LOW: begin
               if (w_go_high) begin
                  r_state <= HIGH;
               end else if (w_hi) begin
                  r_state <= PEND_HIGH;
                  r_pend  <= DEB_WIDTH'(1);
               end
            end
            HIGH: begin
               if (w_go_low) begin
                  r_state <= LOW;
               end else if (w_lo) begin
                  r_state <= PEND_LOW;
                  r_pend  <= DEB_WIDTH'(1);
               end
            end
            PEND_HIGH: begin
               if (w_go_high) begin
                  r_state <= HIGH;
                  r_pend  <= '0;
               end else if (w_hi) begin
                  r_pend  <= w_pend_inc[DEB_WIDTH-1:0];
               end else begin
                  r_state <= LOW;
                  r_pend  <= '0;
               end
            end
            PEND_LOW: begin
               if (w_go_low) begin
                  r_state <= LOW;
                  r_pend  <= '0;
               end else if (w_lo) begin
                  r_pend  <= w_pend_inc[DEB_WIDTH-1:0];
               end else begin
                  r_state <= HIGH;
                  r_pend  <= '0;
               end
            end
            default: begin
               r_state <= ACQ;
               r_pend  <= '0;
            end
         endcase

         // Statistics; a clear in the same cycle as a transition wins over
         // the dwell report but still counts the transition itself.
         if (w_switch) begin
            r_switch      <= 1'b1;
            r_state_o     <= w_go_high;
            r_dwell_cnt   <= CNT_WIDTH'(1);
            r_first_dwell <= 1'b0;
            if (clear_i) begin
               r_n_switch <= CNT_WIDTH'(1);
               r_dwell    <= '0;
            end else begin
               r_n_switch <= w_nsw_inc;
               if (!r_first_dwell) begin
                  r_dwell       <= r_dwell_cnt;
                  r_dwell_valid <= 1'b1;
               end
            end
         end else if (clear_i) begin
            r_n_switch <= '0;
            r_dwell    <= '0;
         end
      end
   end

   assign state_o       = r_state_o;
   assign valid_o       = r_valid;
   assign switch_o      = r_switch;
   assign dwell_o       = r_dwell;
   assign dwell_valid_o = r_dwell_valid;
   assign n_switch_o    = r_n_switch;

endmodule

// File: tb/tb_well_state_detector.sv
// Bench for well_state_detector: directed stimulus pushes expected events
// into a queue; a monitor pops and compares whenever the DUT reports one.
module tb_well_state_detector;

   localparam int WIDTH     = 16;
   localparam int CNT_WIDTH = 32;
   localparam int DEB_WIDTH = 16;

   logic                        clk_i = 1'b0;
   logic                        rst_i;
   logic signed [WIDTH-1:0]     data_i;
   logic signed [WIDTH-1:0]     thr_low_i;
   logic signed [WIDTH-1:0]     thr_high_i;
   logic        [DEB_WIDTH-1:0] debounce_i;
   logic                        clear_i;
   logic                        state_o;
   logic                        valid_o;
   logic                        switch_o;
   logic        [CNT_WIDTH-1:0] dwell_o;
   logic                        dwell_valid_o;
   logic        [CNT_WIDTH-1:0] n_switch_o;

   well_state_detector #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .DEB_WIDTH (DEB_WIDTH)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .data_i        (data_i),
      .thr_low_i     (thr_low_i),
      .thr_high_i    (thr_high_i),
      .debounce_i    (debounce_i),
      .clear_i       (clear_i),
      .state_o       (state_o),
      .valid_o       (valid_o),
      .switch_o      (switch_o),
      .dwell_o       (dwell_o),
      .dwell_valid_o (dwell_valid_o),
      .n_switch_o    (n_switch_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          cyc;
      logic        st;
      logic        v;
      logic        sw;
      logic [31:0] n;
      logic [31:0] dw;
      logic        dv;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_valid = 1'b0;

   // Edge counter: after active edge n, cyc == n.
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   task automatic push(input int c, input logic st, input logic v, input logic sw,
                       input logic [31:0] n, input logic [31:0] dw, input logic dv);
      exp_t e;
      e.cyc = c; e.st = st; e.v = v; e.sw = sw; e.n = n; e.dw = dw; e.dv = dv;
      q.push_back(e);
   endtask

   // Returns at the falling edge just before active edge n, so inputs set
   // afterwards are captured on edge n.
   task automatic wait_until(input int n);
      while (cyc < n - 1) @(negedge clk_i);
   endtask

   // Monitor: an event is a switch pulse, a dwell pulse or valid rising.
   always @(negedge clk_i) begin
      exp_t e;
      if (switch_o || dwell_valid_o || (valid_o && !prev_valid)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event at cyc %0d: sw=%0d dv=%0d n=%0d dwell=%0d, expected none",
                     cyc, switch_o, dwell_valid_o, n_switch_o, dwell_o);
         end else begin
            e = q.pop_front();
            chk("evt_cycle",    cyc,           e.cyc);
            chk("evt_state",    state_o,       e.st);
            chk("evt_valid",    valid_o,       e.v);
            chk("evt_switch",   switch_o,      e.sw);
            chk("evt_n_switch", n_switch_o,    e.n);
            chk("evt_dwell",    dwell_o,       e.dw);
            chk("evt_dwell_v",  dwell_valid_o, e.dv);
         end
      end
      prev_valid = valid_o;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_i      = 1'b1;
      data_i     = '0;
      thr_low_i  = -16'sd1000;
      thr_high_i = 16'sd1000;
      debounce_i = 16'd4;
      clear_i    = 1'b0;

      // Reset state
      wait_until(4);
      rst_i = 1'b0;
      chk("rst_state",    state_o,       0);
      chk("rst_valid",    valid_o,       0);
      chk("rst_switch",   switch_o,      0);
      chk("rst_dwell",    dwell_o,       0);
      chk("rst_dwell_v",  dwell_valid_o, 0);
      chk("rst_n_switch", n_switch_o,    0);

      // Acquisition into HIGH, debounce 4
      wait_until(10);
      data_i = 16'sd2000;
      push(14, 1, 1, 0, 0, 0, 0);

      // HIGH -> LOW (first switch, dwell not reported), back to HIGH after 20
      wait_until(50);
      data_i = -16'sd2000;
      push(54, 0, 1, 1, 1, 0, 0);
      wait_until(70);
      data_i = 16'sd2000;
      push(74, 1, 1, 1, 2, 20, 1);
      wait_until(90);
      data_i = -16'sd2000;
      push(94, 0, 1, 1, 3, 20, 1);

      // Broken run of candidate samples never confirms
      wait_until(110);
      data_i = 16'sd2000;
      wait_until(113);
      data_i = '0;
      wait_until(114);
      data_i = 16'sd2000;
      wait_until(117);
      data_i = '0;
      wait_until(126);
      chk("broken_run_state", state_o, 0);
      chk("broken_run_valid", valid_o, 1);

      // Inverted thresholds: 0 is in-band; debounce 0 confirms in one edge
      wait_until(130);
      thr_low_i  = 16'sd500;
      thr_high_i = -16'sd500;
      debounce_i = '0;
      data_i     = '0;
      wait_until(140);
      data_i = 16'sd2000;
      push(141, 1, 1, 1, 4, 47, 1);
      wait_until(141);
      data_i = '0;
      wait_until(150);
      data_i = -16'sd2000;
      push(151, 0, 1, 1, 5, 10, 1);
      wait_until(151);
      data_i = '0;

      // Clear on the same edge as a transition
      wait_until(170);
      debounce_i = 16'd1;
      data_i     = 16'sd2000;
      push(171, 1, 1, 1, 1, 0, 0);
      wait_until(171);
      clear_i = 1'b1;
      wait_until(172);
      clear_i = 1'b0;
      wait_until(180);
      data_i = -16'sd2000;
      push(181, 0, 1, 1, 2, 10, 1);

      // Reset in the middle of a pending run, then reacquire
      wait_until(190);
      debounce_i = 16'd4;
      data_i     = 16'sd2000;
      wait_until(192);
      rst_i = 1'b1;
      wait_until(193);
      rst_i = 1'b0;
      chk("midrst_state",    state_o,       0);
      chk("midrst_valid",    valid_o,       0);
      chk("midrst_switch",   switch_o,      0);
      chk("midrst_dwell",    dwell_o,       0);
      chk("midrst_dwell_v",  dwell_valid_o, 0);
      chk("midrst_n_switch", n_switch_o,    0);
      push(197, 1, 1, 0, 0, 0, 0);

      wait_until(210);
      chk("pending_events_left", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
